// File: rtl/apu_pkg.sv
// Shared definitions for the square-channel register loader.
//   NUM_SQ_REGS     number of square-channel registers
//   nib_idx_t       3-bit nibble index carried in rx_data[6:4]
//   loader_state_t  pairing FSM states
//   SQ_REG_*        register slot numbers
package apu_pkg;

  localparam int unsigned NUM_SQ_REGS = 4;

  typedef logic [2:0] nib_idx_t;

  typedef enum logic {
    IDLE,
    HAVE_LO
  } loader_state_t;

  localparam int unsigned SQ_REG_DUTY  = 0;
  localparam int unsigned SQ_REG_SWEEP = 1;
  localparam int unsigned SQ_REG_TLO   = 2;
  localparam int unsigned SQ_REG_LEN   = 3;

endpackage

// File: rtl/apu_reg_loader_pair_timeout.sv
// Down-counter that bounds how long a staged low nibble may wait.
//   clk, rst   clock, asynchronous active-high reset
//   load       start a new wait window (count from TIMEOUT_CYCLES-1)
//   clear      stop the window and return the count to 0
//   expired_c  high for the cycle in which an active window has run out
module pair_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired_c
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] count;
  logic          active;

  // Load wins over clear so a restaging byte always opens a fresh window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= TW'(TIMEOUT_CYCLES - 1);
      active <= 1'b1;
    end else if (clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (active && (count != '0)) begin
      count  <= count - TW'(1);
    end
  end

  assign expired_c = active && (count == '0);

endmodule

// File: rtl/apu_reg_loader.sv
// Pairs tagged nibbles from the UART into the four square-channel registers.
//   clk, rst        clock, asynchronous active-high reset
//   rx_data         [7] reserved, [6:4] nibble index, [3:0] nibble data
//   rx_valid        one-cycle strobe qualifying rx_data
//   reg0..reg3      committed duty/sweep/timer-low/length registers
//   reg_wr          one-hot pulse, bit k when regk is committed
//   trig            pulse when reg3 is committed
//   err             pulse on protocol violation or stale half-pair
module apu_reg_loader
  import apu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             reg0,
  output logic [7:0]             reg1,
  output logic [7:0]             reg2,
  output logic [7:0]             reg3,
  output logic [NUM_SQ_REGS-1:0] reg_wr,
  output logic                   trig,
  output logic                   err
);

  loader_state_t                     state;
  logic          [3:0]               lo_nib;
  nib_idx_t                          lo_idx;
  logic          [NUM_SQ_REGS-1:0][7:0] regs;

  logic     rsvd_c;
  nib_idx_t idx_c;
  logic [3:0] nib_c;
  logic [1:0] slot_c;
  logic     pair_match_c;
  logic     load_c;
  logic     clear_c;
  logic     expired_c;

  // Field decode of the incoming byte.
  assign rsvd_c = rx_data[7];
  assign idx_c  = rx_data[6:4];
  assign nib_c  = rx_data[3:0];
  assign slot_c = idx_c[2:1];

  // A staged index is always even, so staged+1 is exactly the matching high index.
  assign pair_match_c = (state == HAVE_LO) && (idx_c == nib_idx_t'(lo_idx + 3'd1));

  // Any even byte (re)opens the window; every other exit from HAVE_LO closes it.
  assign load_c  = rx_valid && !rsvd_c && !idx_c[0];
  assign clear_c = !load_c && (rx_valid || expired_c);

  pair_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .clear    (clear_c),
    .expired_c(expired_c)
  );

  // Pairing FSM and register file; a received byte takes precedence over expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo_nib <= '0;
      lo_idx <= '0;
      regs   <= '0;
      reg_wr <= '0;
      trig   <= 1'b0;
      err    <= 1'b0;
    end else begin
      reg_wr <= '0;
      trig   <= 1'b0;
      err    <= 1'b0;
      if (rx_valid) begin
        if (rsvd_c) begin
          err   <= 1'b1;
          state <= IDLE;
        end else if (!idx_c[0]) begin
          err    <= (state == HAVE_LO);
          lo_nib <= nib_c;
          lo_idx <= idx_c;
          state  <= HAVE_LO;
        end else if (pair_match_c) begin
          regs[slot_c]   <= {nib_c, lo_nib};
          reg_wr[slot_c] <= 1'b1;
          trig           <= (slot_c == 2'(SQ_REG_LEN));
          state          <= IDLE;
        end else begin
          err   <= 1'b1;
          state <= IDLE;
        end
      end else if (expired_c) begin
        err   <= 1'b1;
        state <= IDLE;
      end
    end
  end

  assign reg0 = regs[2'(SQ_REG_DUTY)];
  assign reg1 = regs[2'(SQ_REG_SWEEP)];
  assign reg2 = regs[2'(SQ_REG_TLO)];
  assign reg3 = regs[2'(SQ_REG_LEN)];

endmodule

// File: tb/tb_apu_reg_loader.sv
// Self-checking bench for apu_reg_loader with a short timeout window.
module tb_apu_reg_loader;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] reg0, reg1, reg2, reg3;
  logic [3:0] reg_wr;
  logic       trig;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference: registers, the pending half-pair and its age in cycles.
  logic [7:0] m_reg [4];
  bit         m_pend;
  int         m_pidx;
  logic [3:0] m_pnib;
  int         m_age;
  logic [3:0] m_wr;
  bit         m_trig;
  bit         m_err;

  apu_reg_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .reg0    (reg0),
    .reg1    (reg1),
    .reg2    (reg2),
    .reg3    (reg3),
    .reg_wr  (reg_wr),
    .trig    (trig),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pend = 0; m_pidx = 0; m_pnib = 4'h0; m_age = 0;
    m_wr = 4'h0; m_trig = 0; m_err = 0;
  endfunction

  // Outcome of one clock edge, decided from the protocol rules.
  function automatic void model_edge(input bit v, input logic [7:0] d);
    int idx;
    idx = int'(d[6:4]);
    m_wr = 4'h0; m_trig = 0; m_err = 0;
    if (m_pend) m_age++;
    if (v) begin
      if (d[7]) begin
        m_err = 1; m_pend = 0;
      end else if (idx % 2 == 0) begin
        if (m_pend) m_err = 1;
        m_pend = 1; m_pidx = idx; m_pnib = d[3:0]; m_age = 0;
      end else if (m_pend && idx == m_pidx + 1) begin
        m_reg[idx / 2] = {d[3:0], m_pnib};
        m_wr[idx / 2]  = 1'b1;
        m_trig = (idx == 7);
        m_pend = 0;
      end else begin
        m_err = 1; m_pend = 0;
      end
    end else if (m_pend && m_age == int'(TO)) begin
      m_err = 1; m_pend = 0;
    end
  endfunction

  task automatic compare_all();
    check("reg0", 32'(reg0), 32'(m_reg[0]));
    check("reg1", 32'(reg1), 32'(m_reg[1]));
    check("reg2", 32'(reg2), 32'(m_reg[2]));
    check("reg3", 32'(reg3), 32'(m_reg[3]));
    check("reg_wr", 32'(reg_wr), 32'(m_wr));
    check("trig", 32'(trig), 32'(m_trig));
    check("err", 32'(err), 32'(m_err));
  endtask

  // One clock: drive, advance the model, then compare just after the edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_edge(v, d);
    @(posedge clk);
    #1;
    compare_all();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic pair(input logic [7:0] lo, input logic [7:0] hi,
                      input logic [3:0] wr_lit, input bit trig_lit);
    cycle(1'b1, lo);
    cycle(1'b1, hi);
    check("pair_wr_lit", 32'(reg_wr), 32'(wr_lit));
    check("pair_trig_lit", 32'(trig), 32'(trig_lit));
    check("pair_err_lit", 32'(err), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    idle(2);

    // Jump sequence
    pair(8'h27, 8'h3A, 4'b0010, 1'b0);
    pair(8'h02, 8'h18, 4'b0001, 1'b0);
    pair(8'h4C, 8'h57, 4'b0100, 1'b0);
    pair(8'h69, 8'h70, 4'b1000, 1'b1);
    check("jump_r0", 32'(reg0), 32'h82);
    check("jump_r1", 32'(reg1), 32'hA7);
    check("jump_r2", 32'(reg2), 32'h7C);
    check("jump_r3", 32'(reg3), 32'h09);
    idle(2);

    // Bump sequence
    pair(8'h23, 8'h39, 4'b0010, 1'b0);
    pair(8'h0E, 8'h19, 4'b0001, 1'b0);
    pair(8'h4A, 8'h53, 4'b0100, 1'b0);
    pair(8'h6A, 8'h70, 4'b1000, 1'b1);
    check("bump_r0", 32'(reg0), 32'h9E);
    check("bump_r1", 32'(reg1), 32'h93);
    check("bump_r2", 32'(reg2), 32'h3A);
    check("bump_r3", 32'(reg3), 32'h0A);

    // Orphan and mismatch cases
    cycle(1'b1, 8'h15);
    check("orphan_err", 32'(err), 32'(1));
    check("orphan_wr", 32'(reg_wr), 32'(0));
    cycle(1'b1, 8'h04);
    cycle(1'b1, 8'h33);
    check("mismatch_err", 32'(err), 32'(1));
    check("mismatch_r0", 32'(reg0), 32'h9E);
    check("mismatch_r1", 32'(reg1), 32'h93);
    cycle(1'b1, 8'h04);
    cycle(1'b1, 8'h26);
    check("restage_err", 32'(err), 32'(1));
    cycle(1'b1, 8'h31);
    check("restage_r1", 32'(reg1), 32'h16);
    check("restage_wr", 32'(reg_wr), 32'b0010);

    // Timeout: nothing follows the low nibble for TO cycles
    cycle(1'b1, 8'h4C);
    idle(int'(TO) - 1);
    check("pre_timeout_err", 32'(err), 32'(0));
    idle(1);
    check("timeout_err", 32'(err), 32'(1));
    cycle(1'b1, 8'h57);
    check("late_hi_err", 32'(err), 32'(1));
    check("late_hi_r2", 32'(reg2), 32'h3A);

    // High nibble on the last cycle before expiry
    cycle(1'b1, 8'h4C);
    idle(int'(TO) - 2);
    cycle(1'b1, 8'h57);
    check("edge99_r2", 32'(reg2), 32'h7C);
    check("edge99_err", 32'(err), 32'(0));

    // High nibble coincident with expiry is still accepted
    cycle(1'b1, 8'h41);
    idle(int'(TO) - 1);
    cycle(1'b1, 8'h52);
    check("edge100_r2", 32'(reg2), 32'h21);
    check("edge100_err", 32'(err), 32'(0));

    // Reserved byte
    cycle(1'b1, 8'h6A);
    cycle(1'b1, 8'hFF);
    check("rsvd_err", 32'(err), 32'(1));
    cycle(1'b1, 8'h70);
    check("rsvd_orphan_err", 32'(err), 32'(1));
    check("rsvd_trig", 32'(trig), 32'(0));
    check("rsvd_r3", 32'(reg3), 32'h0A);

    // Reset mid-pair
    cycle(1'b1, 8'h69);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    cycle(1'b1, 8'h70);
    check("post_rst_err", 32'(err), 32'(1));
    check("post_rst_r3", 32'(reg3), 32'h00);

    // Randomized traffic with occasional long gaps to hit expiry
    for (int it = 0; it < 1500; it++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        idle(int'($urandom_range(TO - 5, TO + 5)));
      end else if (r < 40) begin
        cycle(1'b0, 8'($urandom));
      end else begin
        b = 8'($urandom);
        if ($urandom_range(0, 19) != 0) b[7] = 1'b0;
        if (m_pend && $urandom_range(0, 3) != 0) b[6:4] = 3'(m_pidx + 1);
        else if (!m_pend && $urandom_range(0, 3) != 0) b[4] = 1'b0;
        cycle(1'b1, b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
